// File: rtl/nanov_pkg.sv
// Shared types and constants for the nanoV SPI instruction fetcher.
package nanov_pkg;

  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned ADDR_BITS  = 24;
  localparam int unsigned DATA_BITS  = 32;
  localparam int unsigned DUMMY_BITS = 8;
  localparam int unsigned CNT_W      = 6;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_GAP   = 3'd6
  } state_e;

  // Shift order puts the first flash byte on top; the core wants it in [7:0].
  function automatic logic [31:0] le_word(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/nanov_spi_shifter.sv
// Mode-0 SPI bit engine: clk/2 spi_clk, MSB-first transmit, 32-bit receive shift
// register and a bit counter whose done_c flags the edge that completes the segment.
module nanov_spi_shifter
  import nanov_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             arm,
  input  logic             load,
  input  logic             en,
  input  logic [31:0]      tx_data,
  input  logic [CNT_W-1:0] nbits,
  input  logic             miso,
  output logic             spi_clk,
  output logic             mosi,
  output logic [31:0]      rx_word_c,
  output logic             done_c
);

  logic             ph;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      tx;
  logic [31:0]      rx;

  assign rx_word_c = {rx[30:0], miso};
  assign done_c    = en && ph && (cnt == nbits);

  // ph=1 means the next edge is a falling edge: sample miso, advance mosi.
  // arm primes a segment with a falling edge that only presents the first bit.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      spi_clk <= 1'b0;
      mosi    <= 1'b0;
      ph      <= 1'b0;
      cnt     <= '0;
      tx      <= '0;
      rx      <= '0;
    end else if (arm) begin
      spi_clk <= 1'b0;
      ph      <= 1'b1;
      cnt     <= '0;
      tx      <= tx_data;
    end else if (load) begin
      spi_clk <= 1'b0;
      ph      <= 1'b0;
      mosi    <= tx_data[31];
      tx      <= {tx_data[30:0], 1'b0};
      cnt     <= CNT_W'(1);
      rx      <= rx_word_c;
    end else if (en) begin
      if (ph) begin
        spi_clk <= 1'b0;
        ph      <= 1'b0;
        mosi    <= tx[31];
        tx      <= {tx[30:0], 1'b0};
        cnt     <= cnt + CNT_W'(1);
        rx      <= rx_word_c;
      end else begin
        spi_clk <= 1'b1;
        ph      <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/nanov_spi_fetch.sv
// SPI flash instruction fetcher for nanoV_core: READ + 24-bit address, streams LE words.
// Define NANOV_SPI_FAST_READ_EN to use FAST_READ (0x0B) with 8 dummy bits.
module nanov_spi_fetch #(
  parameter int unsigned ADDR_BITS = nanov_pkg::ADDR_BITS,
  parameter logic [7:0]  READ_CMD  = nanov_pkg::CMD_READ
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic                 branch,
  input  logic [ADDR_BITS-1:0] branch_addr,
  input  logic                 instr_ready,
  output logic [31:0]          instr_out,
  output logic                 instr_valid,
  output logic [ADDR_BITS-1:0] pc_out,
  output logic                 spi_cs_n,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);
  import nanov_pkg::*;

`ifdef NANOV_SPI_FAST_READ_EN
  localparam logic [7:0] CMD_BYTE   = CMD_FAST_READ;
  localparam state_e     AFTER_ADDR = ST_DUMMY;
`else
  localparam logic [7:0] CMD_BYTE   = READ_CMD;
  localparam state_e     AFTER_ADDR = ST_DATA;
`endif
  localparam int unsigned ADDR_SHIFT = 32 - ADDR_BITS;

  state_e                 state;
  logic                   gap_cnt;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   restart_c;
  logic                   go_c;
  logic                   sh_clr_c;
  logic                   sh_arm_c;
  logic                   sh_load_c;
  logic                   sh_en_c;
  logic                   sh_done_c;
  logic [CNT_W-1:0]       nbits_c;
  logic [31:0]            tx_c;
  logic [31:0]            rx_word_c;

  assign restart_c = branch && (state != ST_IDLE);
  assign go_c      = (state == ST_IDLE) && (start || branch);
  assign sh_clr_c  = restart_c;
  assign sh_arm_c  = go_c || ((state == ST_GAP) && gap_cnt);
  assign sh_load_c = (((state == ST_CMD) || (state == ST_ADDR) || (state == ST_DUMMY)) && sh_done_c)
                     || ((state == ST_HOLD) && instr_ready);

  // Segment length and transmit payload for the current state.
  always_comb begin
    tx_c    = '0;
    nbits_c = '0;
    sh_en_c = 1'b0;
    case (state)
      ST_IDLE, ST_GAP: tx_c = {CMD_BYTE, 24'h0};
      ST_CMD: begin
        sh_en_c = 1'b1;
        nbits_c = CNT_W'(CMD_BITS);
        tx_c    = 32'(addr_q) << ADDR_SHIFT;
      end
      ST_ADDR: begin
        sh_en_c = 1'b1;
        nbits_c = CNT_W'(ADDR_BITS);
      end
      ST_DUMMY: begin
        sh_en_c = 1'b1;
        nbits_c = CNT_W'(DUMMY_BITS);
      end
      ST_DATA: begin
        sh_en_c = 1'b1;
        nbits_c = CNT_W'(DATA_BITS);
      end
      default: ;
    endcase
  end

  nanov_spi_shifter u_shifter (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (sh_clr_c),
    .arm       (sh_arm_c),
    .load      (sh_load_c),
    .en        (sh_en_c),
    .tx_data   (tx_c),
    .nbits     (nbits_c),
    .miso      (spi_miso),
    .spi_clk   (spi_clk),
    .mosi      (spi_mosi),
    .rx_word_c (rx_word_c),
    .done_c    (sh_done_c)
  );

  // Branch outranks everything outside IDLE, including a same-cycle handshake.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      gap_cnt     <= 1'b0;
      addr_q      <= '0;
      pc_out      <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      spi_cs_n    <= 1'b1;
    end else if (restart_c) begin
      state       <= ST_GAP;
      gap_cnt     <= 1'b0;
      addr_q      <= branch_addr;
      pc_out      <= branch_addr;
      instr_valid <= 1'b0;
      spi_cs_n    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (go_c) begin
          state    <= ST_CMD;
          spi_cs_n <= 1'b0;
          addr_q   <= branch ? branch_addr : start_addr;
          pc_out   <= branch ? branch_addr : start_addr;
        end
        ST_GAP: begin
          if (gap_cnt) begin
            state    <= ST_CMD;
            spi_cs_n <= 1'b0;
            gap_cnt  <= 1'b0;
          end else begin
            gap_cnt <= 1'b1;
          end
        end
        ST_CMD:   if (sh_done_c) state <= ST_ADDR;
        ST_ADDR:  if (sh_done_c) state <= AFTER_ADDR;
        ST_DUMMY: if (sh_done_c) state <= ST_DATA;
        ST_DATA: if (sh_done_c) begin
          state       <= ST_HOLD;
          instr_valid <= 1'b1;
          instr_out   <= le_word(rx_word_c);
        end
        ST_HOLD: if (instr_ready) begin
          state       <= ST_DATA;
          instr_valid <= 1'b0;
          pc_out      <= pc_out + ADDR_BITS'(4);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nanov_spi_fetch.sv
// Self-checking bench: bit-level SPI flash model plus byte-addressed reference memory.
module tb_nanov_spi_fetch;

`ifdef NANOV_SPI_FAST_READ_EN
  localparam int         FIRST_LAT = 145;
  localparam int         HDR_BITS  = 40;
  localparam logic [7:0] EXP_CMD   = 8'h0B;
`else
  localparam int         FIRST_LAT = 129;
  localparam int         HDR_BITS  = 32;
  localparam logic [7:0] EXP_CMD   = 8'h03;
`endif
  localparam int NEXT_LAT = 64;
  localparam int LIMIT    = 400;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [23:0] start_addr = '0;
  logic        branch = 1'b0;
  logic [23:0] branch_addr = '0;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [23:0] pc_out;
  logic        spi_cs_n;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nanov_spi_fetch dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .start_addr  (start_addr),
    .branch      (branch),
    .branch_addr (branch_addr),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .spi_cs_n    (spi_cs_n),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso)
  );

  // Flash contents, filled with random bytes on first touch.
  logic [7:0] mem [logic [23:0]];

  function automatic logic [7:0] get_byte(input logic [23:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic logic [31:0] word_at(input logic [23:0] a);
    return {get_byte(a + 24'd3), get_byte(a + 24'd2), get_byte(a + 24'd1), get_byte(a)};
  endfunction

  // SPI flash: command and address captured on rising spi_clk, data driven after falling.
  int          fl_bits = 0;
  logic [7:0]  fl_cmd = '0;
  logic [23:0] fl_addr = '0;
  logic [7:0]  seen_cmd = '0;
  logic [23:0] seen_addr = '0;

  always @(negedge spi_cs_n) fl_bits = 0;

  always @(posedge spi_clk) begin
    if (!spi_cs_n) begin
      if (fl_bits < 8) fl_cmd = {fl_cmd[6:0], spi_mosi};
      else if (fl_bits < 32) fl_addr = {fl_addr[22:0], spi_mosi};
      fl_bits++;
      if (fl_bits == HDR_BITS) begin
        seen_cmd  = fl_cmd;
        seen_addr = fl_addr;
      end
    end
  end

  always @(negedge spi_clk) begin : fl_drive
    int         d;
    logic [7:0] b;
    if (!spi_cs_n && fl_bits >= HDR_BITS) begin
      d = fl_bits - HDR_BITS;
      b = get_byte(seen_addr + 24'(d / 8));
      #1 spi_miso = b[7 - (d % 8)];
    end
  end

  task automatic do_reset();
    rstn = 1'b0; start = 1'b0; branch = 1'b0; instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic kick_start(input logic [23:0] a);
    start_addr = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (instr_valid !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic accept();
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (spi_cs_n !== 1'b1) begin n_err++; $display("FAIL rst_cs_n got %b want 1", spi_cs_n); end
    n_vec++; if (spi_clk !== 1'b0) begin n_err++; $display("FAIL rst_spi_clk got %b want 0", spi_clk); end
    n_vec++; if (spi_mosi !== 1'b0) begin n_err++; $display("FAIL rst_mosi got %b want 0", spi_mosi); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", instr_valid); end
    n_vec++; if (instr_out !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h want 0", instr_out); end
    n_vec++; if (pc_out !== 24'h0) begin n_err++; $display("FAIL rst_pc got %h want 0", pc_out); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_word();
    int cyc;
    mem[24'h000100] = 8'h93; mem[24'h000101] = 8'h00;
    mem[24'h000102] = 8'h10; mem[24'h000103] = 8'h00;
    kick_start(24'h000100);
    n_vec++; if (spi_cs_n !== 1'b0) begin n_err++; $display("FAIL first_cs_low got %b want 0", spi_cs_n); end
    wait_valid(cyc);
    n_vec++; if (cyc != FIRST_LAT) begin n_err++; $display("FAIL first_latency got %0d want %0d", cyc, FIRST_LAT); end
    n_vec++; if (instr_out !== 32'h00100093) begin n_err++; $display("FAIL first_instr got %h want 00100093", instr_out); end
    n_vec++; if (pc_out !== 24'h000100) begin n_err++; $display("FAIL first_pc got %h want 000100", pc_out); end
    n_vec++; if (seen_cmd !== EXP_CMD) begin n_err++; $display("FAIL first_cmd got %h want %h", seen_cmd, EXP_CMD); end
    n_vec++; if (seen_addr !== 24'h000100) begin n_err++; $display("FAIL first_addr got %h want 000100", seen_addr); end
  endtask

  task automatic test_hold_stall();
    int cyc;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin start_addr = 24'h5A5A5A; start = 1'b1; end
      @(negedge clk);
      start = 1'b0;
      n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %b want 1", i, instr_valid); end
      n_vec++; if (instr_out !== 32'h00100093) begin n_err++; $display("FAIL stall_instr[%0d] got %h want 00100093", i, instr_out); end
      n_vec++; if (spi_clk !== 1'b0) begin n_err++; $display("FAIL stall_spi_clk[%0d] got %b want 0", i, spi_clk); end
    end
    accept();
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL accept_drop got %b want 0", instr_valid); end
    wait_valid(cyc);
    n_vec++; if (cyc != NEXT_LAT) begin n_err++; $display("FAIL next_latency got %0d want %0d", cyc, NEXT_LAT); end
    n_vec++; if (pc_out !== 24'h000104) begin n_err++; $display("FAIL next_pc got %h want 000104", pc_out); end
    n_vec++; if (instr_out !== word_at(24'h000104)) begin n_err++; $display("FAIL next_instr got %h want %h", instr_out, word_at(24'h000104)); end
  endtask

  task automatic test_branch_mid_data();
    int cyc;
    accept();
    repeat (35) @(negedge clk);
    branch_addr = 24'h000200;
    branch = 1'b1;
    @(negedge clk);
    branch = 1'b0;
    n_vec++; if (spi_cs_n !== 1'b1) begin n_err++; $display("FAIL br_cs_hi0 got %b want 1", spi_cs_n); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL br_valid got %b want 0", instr_valid); end
    n_vec++; if (pc_out !== 24'h000200) begin n_err++; $display("FAIL br_pc_load got %h want 000200", pc_out); end
    @(negedge clk);
    n_vec++; if (spi_cs_n !== 1'b1) begin n_err++; $display("FAIL br_cs_hi1 got %b want 1", spi_cs_n); end
    @(negedge clk);
    n_vec++; if (spi_cs_n !== 1'b0) begin n_err++; $display("FAIL br_cs_relow got %b want 0", spi_cs_n); end
    wait_valid(cyc);
    n_vec++; if (cyc != FIRST_LAT) begin n_err++; $display("FAIL br_latency got %0d want %0d", cyc, FIRST_LAT); end
    n_vec++; if (pc_out !== 24'h000200) begin n_err++; $display("FAIL br_pc got %h want 000200", pc_out); end
    n_vec++; if (instr_out !== word_at(24'h000200)) begin n_err++; $display("FAIL br_instr got %h want %h", instr_out, word_at(24'h000200)); end
    n_vec++; if (seen_addr !== 24'h000200) begin n_err++; $display("FAIL br_flash_addr got %h want 000200", seen_addr); end
    n_vec++; if (seen_cmd !== EXP_CMD) begin n_err++; $display("FAIL br_flash_cmd got %h want %h", seen_cmd, EXP_CMD); end
  endtask

  task automatic test_branch_handshake();
    int          cyc;
    logic [23:0] ba;
    ba = 24'($urandom);
    branch_addr = ba;
    branch = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    branch = 1'b0;
    instr_ready = 1'b0;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL bh_valid got %b want 0", instr_valid); end
    n_vec++; if (pc_out !== ba) begin n_err++; $display("FAIL bh_pc got %h want %h", pc_out, ba); end
    n_vec++; if (spi_cs_n !== 1'b1) begin n_err++; $display("FAIL bh_cs got %b want 1", spi_cs_n); end
    wait_valid(cyc);
    n_vec++; if (cyc != FIRST_LAT + 2) begin n_err++; $display("FAIL bh_latency got %0d want %0d", cyc, FIRST_LAT + 2); end
    n_vec++; if (pc_out !== ba) begin n_err++; $display("FAIL bh_word_pc got %h want %h", pc_out, ba); end
    n_vec++; if (instr_out !== word_at(ba)) begin n_err++; $display("FAIL bh_instr got %h want %h", instr_out, word_at(ba)); end
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset();
    kick_start(24'hFFFFFC);
    wait_valid(cyc);
    n_vec++; if (pc_out !== 24'hFFFFFC) begin n_err++; $display("FAIL wrap_pc0 got %h want fffffc", pc_out); end
    n_vec++; if (instr_out !== word_at(24'hFFFFFC)) begin n_err++; $display("FAIL wrap_instr0 got %h want %h", instr_out, word_at(24'hFFFFFC)); end
    accept();
    wait_valid(cyc);
    n_vec++; if (cyc != NEXT_LAT) begin n_err++; $display("FAIL wrap_latency got %0d want %0d", cyc, NEXT_LAT); end
    n_vec++; if (pc_out !== 24'h000000) begin n_err++; $display("FAIL wrap_pc1 got %h want 000000", pc_out); end
    n_vec++; if (instr_out !== word_at(24'h000000)) begin n_err++; $display("FAIL wrap_instr1 got %h want %h", instr_out, word_at(24'h000000)); end
  endtask

  task automatic test_reset_mid_addr();
    do_reset();
    kick_start(24'($urandom));
    repeat (30) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    n_vec++; if (spi_cs_n !== 1'b1) begin n_err++; $display("FAIL mrst_cs got %b want 1", spi_cs_n); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL mrst_valid got %b want 0", instr_valid); end
    n_vec++; if (spi_clk !== 1'b0) begin n_err++; $display("FAIL mrst_spi_clk got %b want 0", spi_clk); end
    n_vec++; if (pc_out !== 24'h0) begin n_err++; $display("FAIL mrst_pc got %h want 0", pc_out); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random_stream();
    int          cyc;
    logic [23:0] exp_pc;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      exp_pc = 24'($urandom);
      kick_start(exp_pc);
      for (int w = 0; w < 5; w++) begin
        wait_valid(cyc);
        n_vec++; if (cyc != ((w == 0) ? FIRST_LAT : NEXT_LAT)) begin n_err++; $display("FAIL rs_latency[%0d.%0d] got %0d want %0d", r, w, cyc, (w == 0) ? FIRST_LAT : NEXT_LAT); end
        n_vec++; if (pc_out !== exp_pc) begin n_err++; $display("FAIL rs_pc[%0d.%0d] got %h want %h", r, w, pc_out, exp_pc); end
        n_vec++; if (instr_out !== word_at(exp_pc)) begin n_err++; $display("FAIL rs_instr[%0d.%0d] got %h want %h", r, w, instr_out, word_at(exp_pc)); end
        repeat ($urandom_range(0, 6)) @(negedge clk);
        accept();
        exp_pc = exp_pc + 24'd4;
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_hold_stall();
    test_branch_mid_data();
    test_branch_handshake();
    test_wrap();
    test_reset_mid_addr();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, got timeout want finish");
    $fatal(1);
  end

endmodule
